// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 frames of one 32-bit word each.
// Ports: CLK/nRST; datapath side imemREN, imemaddr -> ihit, imemload;
// memory side iREN, iaddr <- iwait, iload; hit_count/miss_count stats.
module icache (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t      state;
    logic [15:0] valid;
    logic [25:0] tags [16];
    logic [31:0] data [16];

    logic [3:0]  idx;
    logic [3:0]  fidx;
    logic        tag_eq;
    logic        fill;
    logic        unused_bits;

    assign idx         = imemaddr[5:2];
    assign fidx        = iaddr[5:2];
    assign tag_eq      = (tags[idx] == imemaddr[31:6]);
    assign fill        = (state == MISS) && !iwait;
    assign unused_bits = ^{imemaddr[1:0], iaddr[1:0]};

    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0;
        if (state == IDLE && imemREN && valid[idx] && tag_eq) begin
            ihit     = 1'b1;
            imemload = data[idx];
        end
    end

    // iaddr doubles as the miss-address register; it is only non-zero
    // while a fill is outstanding, so it is cleared on completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            iREN       <= 1'b0;
            iaddr      <= 32'h0;
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            unique case (state)
                IDLE: begin
                    if (imemREN && !ihit) begin
                        state <= MISS;
                        iREN  <= 1'b1;
                        iaddr <= {imemaddr[31:2], 2'b00};
                    end
                end
                MISS: begin
                    // The fill always completes for the latched address,
                    // even if the pipeline has moved on meanwhile.
                    if (fill) begin
                        state       <= IDLE;
                        iREN        <= 1'b0;
                        iaddr       <= 32'h0;
                        valid[fidx] <= 1'b1;
                        if (miss_count != 32'hFFFF_FFFF)
                            miss_count <= miss_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data need no reset: lookups are qualified by valid. The fill
    // cannot fire during reset because state is held at IDLE.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[fidx] <= iaddr[31:6];
            data[fidx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_tests;
    int n_fail;
    int exp_hits;
    int exp_miss;

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Stimulus only: take one miss on addr and fill it after nwait busy cycles.
    task automatic do_fill(input logic [31:0] addr, input logic [31:0] d,
                           input int nwait);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        step();
        for (int i = 0; i < nwait; i++) step();
        iwait = 1'b0;
        iload = d;
        step();
        imemREN = 1'b0;
        iwait   = 1'b1;
        exp_miss++;
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        iwait    = 1'b0;
        iload    = 32'hDEAD_BEEF;
        step();
        step();
        #1;
        n_tests++;
        if ({ihit, iREN} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctl ihit,iREN got %b want 00", {ihit, iREN});
        end
        n_tests++;
        if (iaddr !== 32'h0 || imemload !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus iaddr=%h imemload=%h want 0", iaddr, imemload);
        end
        n_tests++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt hit=%0d miss=%0d want 0", hit_count, miss_count);
        end
        imemREN = 1'b0;
        iwait   = 1'b1;
        @(negedge CLK);
        nRST     = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic test_cold_miss();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iwait    = 1'b1;
        iload    = 32'h2002_0001;
        #1;
        n_tests++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_idle ihit=%b iREN=%b want 0 0", ihit, iREN);
        end
        step();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) iwait = 1'b0;
            #1;
            n_tests++;
            if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
                n_fail++;
                $display("FAIL cold_miss_c%0d iREN=%b iaddr=%h ihit=%b want 1 40 0",
                         c, iREN, iaddr, ihit);
            end
            step();
        end
        exp_miss++;
        iwait = 1'b1;
        #1;
        n_tests++;
        if (ihit !== 1'b1 || imemload !== 32'h2002_0001) begin
            n_fail++;
            $display("FAIL cold_hit ihit=%b imemload=%h want 1 20020001", ihit, imemload);
        end
        n_tests++;
        if (miss_count !== 32'd1 || iREN !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_cnt miss=%0d iREN=%b want 1 0", miss_count, iREN);
        end
        step();
        exp_hits++;
        imemREN = 1'b0;
        #1;
        n_tests++;
        if (hit_count !== 32'(exp_hits)) begin
            n_fail++;
            $display("FAIL cold_hitcnt got %0d want %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_conflict();
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        #1;
        n_tests++;
        if (ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_80_miss ihit=%b want 0", ihit);
        end
        do_fill(32'h80, 32'hAAAA_0080, 1);
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        #1;
        n_tests++;
        if (ihit !== 1'b1 || imemload !== 32'hAAAA_0080) begin
            n_fail++;
            $display("FAIL conflict_80_hit ihit=%b data=%h want 1 aaaa0080", ihit, imemload);
        end
        imemaddr = 32'h40;
        #1;
        n_tests++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            n_fail++;
            $display("FAIL conflict_40_evicted ihit=%b data=%h want 0 0", ihit, imemload);
        end
        do_fill(32'h40, 32'h2002_0001, 0);
        #1;
        n_tests++;
        if (miss_count !== 32'd3) begin
            n_fail++;
            $display("FAIL conflict_misscnt got %0d want 3", miss_count);
        end
    endtask

    task automatic test_squash();
        imemREN  = 1'b1;
        imemaddr = 32'h100;
        iwait    = 1'b1;
        step();
        imemaddr = 32'h200;
        #1;
        n_tests++;
        if (iaddr !== 32'h100 || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_addr iaddr=%h ihit=%b want 100 0", iaddr, ihit);
        end
        step();
        imemREN = 1'b0;
        #1;
        n_tests++;
        if (iREN !== 1'b1 || iaddr !== 32'h100) begin
            n_fail++;
            $display("FAIL squash_hold iREN=%b iaddr=%h want 1 100", iREN, iaddr);
        end
        iwait = 1'b0;
        iload = 32'hBBBB_0100;
        step();
        iwait = 1'b1;
        exp_miss++;
        imemREN  = 1'b1;
        imemaddr = 32'h200;
        #1;
        n_tests++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_200 ihit=%b iREN=%b want 0 0", ihit, iREN);
        end
        imemaddr = 32'h100;
        #1;
        n_tests++;
        if (ihit !== 1'b1 || imemload !== 32'hBBBB_0100) begin
            n_fail++;
            $display("FAIL squash_100 ihit=%b data=%h want 1 bbbb0100", ihit, imemload);
        end
        n_tests++;
        if (miss_count !== 32'(exp_miss)) begin
            n_fail++;
            $display("FAIL squash_misscnt got %0d want %0d", miss_count, exp_miss);
        end
        imemREN = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        imemREN  = 1'b1;
        imemaddr = 32'h44;
        iwait    = 1'b1;
        step();
        step();
        nRST = 1'b0;
        #1;
        n_tests++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmiss_drop iREN=%b iaddr=%h want 0 0", iREN, iaddr);
        end
        n_tests++;
        if (miss_count !== 32'h0 || hit_count !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmiss_cnt miss=%0d hit=%0d want 0 0", miss_count, hit_count);
        end
        iwait = 1'b0;
        iload = 32'hEEEE_EEEE;
        step();
        nRST     = 1'b1;
        iwait    = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
        imemaddr = 32'h100;
        #1;
        n_tests++;
        if (ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmiss_valid_clr ihit=%b want 0", ihit);
        end
        imemaddr = 32'h44;
        #1;
        n_tests++;
        if (ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmiss_again ihit=%b want 0", ihit);
        end
        step();
        #1;
        n_tests++;
        if (iREN !== 1'b1 || iaddr !== 32'h44) begin
            n_fail++;
            $display("FAIL rstmiss_refill iREN=%b iaddr=%h want 1 44", iREN, iaddr);
        end
        iwait = 1'b0;
        iload = 32'hCCCC_0044;
        step();
        iwait = 1'b1;
        exp_miss++;
        #1;
        n_tests++;
        if (ihit !== 1'b1 || imemload !== 32'hCCCC_0044 || miss_count !== 32'd1) begin
            n_fail++;
            $display("FAIL rstmiss_hit ihit=%b data=%h miss=%0d want 1 cccc0044 1",
                     ihit, imemload, miss_count);
        end
        imemREN = 1'b0;
    endtask

    task automatic test_unaligned_idle();
        do_fill(32'h40, 32'h2002_0001, 2);
        imemREN  = 1'b1;
        imemaddr = 32'h43;
        #1;
        n_tests++;
        if (ihit !== 1'b1 || imemload !== 32'h2002_0001) begin
            n_fail++;
            $display("FAIL unaligned ihit=%b data=%h want 1 20020001", ihit, imemload);
        end
        step();
        exp_hits++;
        imemREN = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (ihit !== 1'b0 || iREN !== 1'b0 || hit_count !== 32'(exp_hits)) begin
                n_fail++;
                $display("FAIL idle_c%0d ihit=%b iREN=%b hit=%0d want 0 0 %0d",
                         c, ihit, iREN, hit_count, exp_hits);
            end
            step();
        end
        n_tests++;
        if (miss_count !== 32'(exp_miss)) begin
            n_fail++;
            $display("FAIL idle_misscnt got %0d want %0d", miss_count, exp_miss);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        imemREN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            a = (c % 2 == 0) ? 32'h40 : 32'h44;
            d = (c % 2 == 0) ? 32'h2002_0001 : 32'hCCCC_0044;
            imemaddr = a;
            #1;
            n_tests++;
            if (ihit !== 1'b1 || imemload !== d) begin
                n_fail++;
                $display("FAIL b2b_c%0d ihit=%b data=%h want 1 %h", c, ihit, imemload, d);
            end
            step();
            exp_hits++;
        end
        imemREN = 1'b0;
        #1;
        n_tests++;
        if (hit_count !== 32'(exp_hits)) begin
            n_fail++;
            $display("FAIL b2b_hitcnt got %0d want %0d", hit_count, exp_hits);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_hits = 0;
        exp_miss = 0;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;
        @(negedge CLK);
        test_reset();
        test_cold_miss();
        test_conflict();
        test_squash();
        test_reset_mid_miss();
        test_unaligned_idle();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
